// File: rtl/bram_rd_pkg.sv
// -----------------------------------------------------------------------------
// bram_rd_pkg
// Shared definitions for the BRAM stream reader:
//   state_e      : transfer FSM encoding (IDLE, RUN, DONE)
//   BUF_DEPTH    : entries in the output skid buffer
//   CREDIT_LIMIT : reads allowed to be buffered or in flight at once
// -----------------------------------------------------------------------------
package bram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int BUF_DEPTH    = 2;

    // Every issued read must have a buffer slot waiting for it, so the credit
    // limit equals the buffer depth.
    localparam int CREDIT_LIMIT = BUF_DEPTH;

endpackage

// File: rtl/bram_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// bram_rd_skid_buf
// Two-entry FIFO of {data, last} between the BRAM read pipe and the stream.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data/push_last this cycle (BRAM data is valid)
//   push_data  : BRAM read data
//   push_last  : word is the final one of the transfer
//   pop        : head entry is consumed this cycle (stream handshake)
//   count      : current occupancy, 0..2
//   head_data  : oldest entry data
//   head_last  : oldest entry last flag
// -----------------------------------------------------------------------------
module bram_rd_skid_buf
    import bram_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last
);

    // Depth is fixed at two, so a single bit addresses an entry.
    logic [DATA_WIDTH-1:0] data_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [BUF_DEPTH];
    logic                  last_q [BUF_DEPTH];
    logic                  last_d [BUF_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q,  count_d;

    // NOTE: every signal written here gets its default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset as well because the head entry drives
            // the stream data output directly, which must read 0 in reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];

    // The issue rule never lets a read land in a full buffer, with or without
    // a pop in the same cycle.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'(BUF_DEPTH))));

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Reads `length` consecutive words from a registered-output BRAM port starting
// at `base_addr` and presents them on a valid/ready stream with a last flag.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : command strobe, honoured only while busy is low
//   base_addr, length   : transfer descriptor captured on an accepted start
//   busy, done          : busy from accepted start through the done pulse
//   ram_addr, ram_we,
//   ram_re, ram_rdata   : BRAM port (1-cycle read latency, read-only use)
//   m_data, m_valid,
//   m_ready, m_last     : output stream
// -----------------------------------------------------------------------------
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q,        state_d;
    logic                  busy_q,         busy_d;
    logic                  done_q,         done_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,     ram_addr_d;
    logic [ADDR_WIDTH:0]   issue_left_q,   issue_left_d;
    logic [ADDR_WIDTH:0]   beats_left_q,   beats_left_d;
    logic                  in_flight_q,    in_flight_d;
    logic                  in_flight_last_q, in_flight_last_d;

    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic                  pop;
    logic [1:0]            committed;

    assign m_valid = (buf_count != 2'd0);
    assign pop     = m_valid && m_ready;

    // Words that will occupy the buffer after this cycle's pop. Counting the
    // slot freed by a pop in the same cycle is what sustains one beat per
    // cycle through a two-entry buffer.
    assign committed = buf_count - {1'b0, pop} + {1'b0, in_flight_q};

    // ram_addr already holds the next address, so a read is issued simply by
    // raising ram_re while credit remains.
    assign ram_re = (state_q == ST_RUN) && (issue_left_q != '0) &&
                    (committed < 2'(CREDIT_LIMIT));

    always_comb begin
        state_d          = state_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        ram_addr_d       = ram_addr_q;
        issue_left_d     = issue_left_q;
        beats_left_d     = beats_left_q;
        in_flight_d      = ram_re;
        in_flight_last_d = ram_re && (issue_left_q == CNT_ONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d       = 1'b1;
                    ram_addr_d   = base_addr;
                    issue_left_d = length;
                    beats_left_d = length;
                    if (length == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (ram_re) begin
                    // Wrapping past the top address is intended.
                    ram_addr_d   = ram_addr_q + ADDR_ONE;
                    issue_left_d = issue_left_q - CNT_ONE;
                end
                if (pop) begin
                    beats_left_d = beats_left_q - CNT_ONE;
                    if (beats_left_q == CNT_ONE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            ram_addr_q       <= '0;
            issue_left_q     <= '0;
            beats_left_q     <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            ram_addr_q       <= ram_addr_d;
            issue_left_q     <= issue_left_d;
            beats_left_q     <= beats_left_d;
            in_flight_q      <= in_flight_d;
            in_flight_last_q <= in_flight_last_d;
        end
    end

    // The read issued last cycle is on ram_rdata now; capture it.
    bram_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight_q),
        .push_data (ram_rdata),
        .push_last (in_flight_last_q),
        .pop       (pop),
        .count     (buf_count),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_addr = ram_addr_q;
    assign ram_we   = 1'b0;
    assign m_data   = head_data;
    // Stale entries may carry an old last flag; only a valid head counts.
    assign m_last   = m_valid && head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_we, ram_re, m_valid, m_last;
    logic          m_ready = 1'b1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] m_data;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // Registered-read BRAM model, no enable.
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    // ---------------------------------------------------------------- monitor
    logic [DW-1:0] beat_data [$];
    logic          beat_last [$];
    int            beat_neg  [$];
    logic [AW-1:0] addr_q    [$];
    int            done_neg  [$];
    int            neg_cnt    = 0;
    int            vld_cnt    = 0;
    int            issued     = 0;
    int            popped     = 0;
    int            cap_bad    = 0;
    int            stall_bad  = 0;
    int            stall_seen = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always @(negedge clk) begin
        neg_cnt <= neg_cnt + 1;
        if (rst) begin
            issued     <= 0;
            popped     <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                beat_data.push_back(m_data);
                beat_last.push_back(m_last);
                beat_neg.push_back(neg_cnt + 1);
            end
            if (ram_re) addr_q.push_back(ram_addr);
            if (done) done_neg.push_back(neg_cnt + 1);
            if (m_valid) vld_cnt <= vld_cnt + 1;
            // Reads issued but not yet consumed must fit in the 2-entry buffer.
            if (ram_re && (issued - popped + 1 - ((m_valid && m_ready) ? 1 : 0)) > 2)
                cap_bad <= cap_bad + 1;
            if (prev_stall) begin
                stall_seen <= stall_seen + 1;
                if (!(m_valid && m_data == prev_data && m_last == prev_last))
                    stall_bad <= stall_bad + 1;
            end
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
            issued     <= issued + (ram_re ? 1 : 0);
            popped     <= popped + ((m_valid && m_ready) ? 1 : 0);
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_pattern(input int k);
        if (k < 6)       return (k % 2) == 0;
        else if (k < 11) return 1'b0;
        else             return (k % 2) == 0;
    endfunction

    // mode 0: m_ready held 1; mode 1: toggling with a 5-cycle stall.
    task automatic run_xfer(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                            input logic [DW-1:0] exp_first, input logic [DW-1:0] exp_last,
                            input string tag);
        int b0, a0, d0, v0, s, k, nb, na, data_err, last_err, addr_err;
        logic [AW-1:0] a;
        b0 = beat_data.size();
        a0 = addr_q.size();
        d0 = done_neg.size();
        v0 = vld_cnt;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        m_ready   = (mode == 0) ? 1'b1 : ready_pattern(0);
        s = neg_cnt + 1;
        k = 0;
        while (done_neg.size() == d0 && k < 3000) begin
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            m_ready = (mode == 0) ? 1'b1 : ready_pattern(k);
        end
        m_ready = 1'b1;
        check({tag, "_done_seen"}, 32'(done_neg.size() > d0), 32'd1);
        nb = beat_data.size() - b0;
        na = addr_q.size() - a0;
        check({tag, "_beats"}, 32'(nb), 32'(len));
        check({tag, "_reads"}, 32'(na), 32'(len));
        data_err = 0;
        last_err = 0;
        addr_err = 0;
        for (int i = 0; i < nb; i++) begin
            a = base + AW'(i);
            if (beat_data[b0 + i] !== a[DW-1:0]) data_err++;
            if (beat_last[b0 + i] !== (i == nb - 1)) last_err++;
        end
        for (int i = 0; i < na; i++) begin
            a = base + AW'(i);
            if (addr_q[a0 + i] !== a) addr_err++;
        end
        check({tag, "_data_seq_errs"}, 32'(data_err), 32'd0);
        check({tag, "_last_errs"}, 32'(last_err), 32'd0);
        check({tag, "_addr_errs"}, 32'(addr_err), 32'd0);
        if (len == 0) begin
            check({tag, "_valid_cycles"}, 32'(vld_cnt - v0), 32'd0);
            if (done_neg.size() > d0)
                check({tag, "_done_latency"}, 32'(done_neg[d0] - s), 32'd1);
        end else if (nb > 0) begin
            check({tag, "_first_data"}, 32'(beat_data[b0]), 32'(exp_first));
            check({tag, "_last_data"}, 32'(beat_data[b0 + nb - 1]), 32'(exp_last));
            if (done_neg.size() > d0)
                check({tag, "_done_after_last"}, 32'(done_neg[d0] - beat_neg[b0 + nb - 1]), 32'd1);
            if (mode == 0) begin
                check({tag, "_first_latency"}, 32'(beat_neg[b0] - s), 32'd3);
                check({tag, "_no_bubbles"}, 32'(beat_neg[b0 + nb - 1] - beat_neg[b0]), 32'(nb - 1));
            end
        end
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;
        logic [DW-1:0] first;
        logic [DW-1:0] last;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, k;
        logic seen_done_start;

        for (int i = 0; i < (1 << AW); i++) mem[i] = i[DW-1:0];

        vecs[0] = '{base: 10'd5,    len: 11'd4,    mode: 0, first: 8'h05, last: 8'h08};
        vecs[1] = '{base: 10'd1022, len: 11'd4,    mode: 0, first: 8'hFE, last: 8'h01};
        vecs[2] = '{base: 10'd100,  len: 11'd1,    mode: 0, first: 8'h64, last: 8'h64};
        vecs[3] = '{base: 10'd0,    len: 11'd0,    mode: 0, first: 8'h00, last: 8'h00};
        vecs[4] = '{base: 10'd0,    len: 11'd8,    mode: 1, first: 8'h00, last: 8'h07};
        vecs[5] = '{base: 10'd1023, len: 11'd1024, mode: 0, first: 8'hFF, last: 8'hFE};
        vecs[6] = '{base: 10'd200,  len: 11'd3,    mode: 0, first: 8'hC8, last: 8'hCA};

        // Reset state
        #1;
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_re",   32'(ram_re),   32'd0);
        check("rst_ram_we",   32'(ram_we),   32'd0);
        check("rst_m_valid",  32'(m_valid),  32'd0);
        check("rst_m_last",   32'(m_last),   32'd0);
        check("rst_m_data",   32'(m_data),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 7; v++)
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].first, vecs[v].last,
                     $sformatf("vec%0d", v));

        // Start while busy and start coincident with done are both ignored.
        b0 = beat_data.size();
        d0 = done_neg.size();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd40; length = 11'd3;
        k = 0;
        seen_done_start = 1'b0;
        while (!seen_done_start && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (done) begin
                start = 1'b1; base_addr = 10'd500; length = 11'd5;
                seen_done_start = 1'b1;
            end else if (k == 2) begin
                start = 1'b1; base_addr = 10'd500; length = 11'd5;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("ign_done_start_applied", 32'(seen_done_start), 32'd1);
        check("ign_beats", 32'(beat_data.size() - b0), 32'd3);
        if (beat_data.size() - b0 == 3) begin
            check("ign_data0", 32'(beat_data[b0]),     32'h28);
            check("ign_data2", 32'(beat_data[b0 + 2]), 32'h2A);
            check("ign_last2", 32'(beat_last[b0 + 2]), 32'd1);
        end
        check("ign_done_count", 32'(done_neg.size() - d0), 32'd1);
        check("ign_busy_after", 32'(busy), 32'd0);

        // Reset in the middle of a 6-word transfer, after beat 2.
        b0 = beat_data.size();
        d0 = done_neg.size();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd0; length = 11'd6; m_ready = 1'b1;
        k = 0;
        while (beat_data.size() - b0 < 2 && k < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        check("mid_two_beats", 32'(beat_data.size() - b0), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_ram_addr", 32'(ram_addr), 32'd0);
        check("arst_ram_re",   32'(ram_re),   32'd0);
        check("arst_m_valid",  32'(m_valid),  32'd0);
        check("arst_m_last",   32'(m_last),   32'd0);
        check("arst_m_data",   32'(m_data),   32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_beats", 32'(beat_data.size() - b0), 32'd2);
        check("post_rst_no_done",  32'(done_neg.size() - d0), 32'd0);
        check("post_rst_busy",     32'(busy), 32'd0);
        run_xfer(10'd10, 11'd2, 0, 8'h0A, 8'h0B, "after_rst");

        check("read_credit_violations", 32'(cap_bad), 32'd0);
        check("stall_cycles_seen", 32'(stall_seen > 0), 32'd1);
        check("stall_instability", 32'(stall_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
